vend_sched: RTL and testbench
=============================

VEND_SCHED -- requirements
Module: vend_sched

Interface
REQ-001 SHALL have parameter PRICE, 4, coin units needed per item.
REQ-002 SHALL have parameter TIMEOUT, 16, idle cycles in COLLECT before a refund.
REQ-003 SHALL have parameter STOCK_W, 8, stock counter width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports coin_a_vld / coin_b_vld  input  1  coin offered on channel A / B.
REQ-007 SHALL have ports coin_a_val / coin_b_val  input  2  coin value (1 = 1 unit, 2 = 2 units, 0/3 = invalid).
REQ-008 SHALL have ports coin_a_rdy / coin_b_rdy  output  1  coin accepted this cycle when vld & rdy.
REQ-009 SHALL have port restock_vld  input  1  add restock_cnt to stock.
REQ-010 SHALL have port restock_cnt  input  STOCK_W  items to add.
REQ-011 SHALL have ports dispense_vld (output, 1), dispense_ack (input, 1), dispense_chn (output, 1; 0 = A, 1 = B), dispense_chg (output, 2; change units).
REQ-012 SHALL have ports refund_vld (output, 1; one-cycle pulse), refund_chn (output, 1), refund_val (output, 3).
REQ-013 SHALL have ports bad_coin (output, 1; one-cycle pulse), sold_out (output, 1), stock (output, STOCK_W), busy (output, 1; state != IDLE).

Function
REQ-014 SHALL implement the states IDLE, COLLECT, DISPENSE and REFUND, with one channel owning the machine outside IDLE.
REQ-015 SHALL, in IDLE with stock != 0, assert rdy to exactly one requesting channel: if only one vld is high, that channel; if both are high, the channel given by the round-robin pointer.
REQ-016 SHALL, in COLLECT, assert rdy only to the owner, and SHALL hold both rdy low in DISPENSE and REFUND and whenever stock == 0 in IDLE.
REQ-017 SHALL, on an accepted valid coin in IDLE, latch the owner, set credit to the coin value and enter COLLECT, unless the coin value is at least PRICE.
REQ-018 SHALL, on an accepted valid coin where credit + value >= PRICE, enter DISPENSE on the next edge with dispense_vld = 1, dispense_chn = owner and dispense_chg = credit + value - PRICE.
REQ-019 SHALL hold dispense_vld and its data stable until dispense_ack is sampled high.
REQ-020 SHALL, on the dispense_ack edge, decrement stock, clear credit, flip the round-robin pointer away from the owner and return to IDLE.
REQ-021 SHALL, on an accepted invalid coin (value 0 or 3), complete the handshake, pulse bad_coin on the next cycle, leave credit unchanged, and not claim ownership when in IDLE.
REQ-022 SHALL clear the timeout counter on every accepted coin; when the counter reaches TIMEOUT-1 in COLLECT, it SHALL enter REFUND.
REQ-023 SHALL, in REFUND, spend exactly one cycle with refund_vld = 1, refund_chn = owner and refund_val = credit, then clear credit, flip the pointer and go to IDLE.
REQ-024 SHALL add restock_cnt to stock, saturating at 2^STOCK_W-1, in any state; restock and a decrement in the same cycle SHALL give sat(stock + cnt) - 1.
REQ-025 SHALL drive sold_out = (stock == 0), with no further arbitration grants after stock reaches 0.
REQ-026 SHALL hold credit in 3 bits, with a maximum value of PRICE+1.

Reset
REQ-027 SHALL, on rst, clear the state to IDLE, credit and the timeout counter to 0, the pointer to A, stock to 0, and all valid and pulse outputs to 0.
REQ-028 SHALL drop an in-flight transaction on reset mid-operation, with no dispense or refund issued.

Structure
REQ-029 SHALL place the state enum, the coin encodings, and the PRICE/TIMEOUT defaults in a shared package vend_pkg.
REQ-030 SHALL implement the two-way round-robin grant as the sub-module vend_rr_arb.

Verification
REQ-031 SHALL cover: restock 5; channel A inserts 1,1,1,1 -> dispense_vld with chn 0 and chg 0; ack -> stock 4.
REQ-032 SHALL cover: channel B inserts 2,2 with A idle -> dispense chn 1, chg 0; channel A inserts 1,1,1,2 -> chg 1.
REQ-033 SHALL cover: A and B both vld in IDLE with pointer = A -> A granted; A owns until ack; next contest -> B granted.
REQ-034 SHALL cover: A inserts 1, then idles for TIMEOUT cycles -> refund_vld for one cycle with chn 0 and val 1; machine returns to IDLE.
REQ-035 SHALL cover: stock 1; a sale completes -> sold_out = 1 and both rdy stay low; restock 3 in the same cycle as ack -> stock 3.
REQ-036 SHALL cover: a coin value of 3 -> bad_coin pulse with credit unchanged; rst asserted in DISPENSE -> all outputs 0 and stock 0.

Source files
------------

// File: rtl/vend_pkg.sv
// vend_pkg -- shared definitions for the vending scheduler.
//   PRICE_DEF / TIMEOUT_DEF : default price (coin units) and COLLECT idle timeout
//   state_t                 : machine states
//   COIN_ONE / COIN_TWO     : the only valid coin encodings (others are rejected)
//   CHN_A / CHN_B           : channel identifiers used for ownership and arbitration
package vend_pkg;

  localparam int PRICE_DEF   = 4;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_REFUND   = 2'd3
  } state_t;

  localparam logic [1:0] COIN_ONE = 2'd1;
  localparam logic [1:0] COIN_TWO = 2'd2;

  localparam logic CHN_A = 1'b0;
  localparam logic CHN_B = 1'b1;

  // Coin value in units; invalid encodings are worth nothing.
  function automatic logic [2:0] coin_units(input logic [1:0] val);
    case (val)
      COIN_ONE: coin_units = 3'd1;
      COIN_TWO: coin_units = 3'd2;
      default:  coin_units = 3'd0;
    endcase
  endfunction

  function automatic logic coin_ok(input logic [1:0] val);
    coin_ok = (val == COIN_ONE) || (val == COIN_TWO);
  endfunction

endpackage

// File: rtl/vend_rr_arb.sv
// vend_rr_arb -- two-way round-robin grant for the coin channels.
//   clk, rst     : clock, asynchronous active-high reset
//   en           : grants allowed this cycle
//   req_a, req_b : channel requests
//   upd, last    : on upd, the preference moves away from channel 'last'
//   gnt_a, gnt_b : one-hot (or zero) grant
module vend_rr_arb
  import vend_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  input  logic upd,
  input  logic last,
  output logic gnt_a,
  output logic gnt_b
);

  logic ptr;

  // Preference pointer: the channel that wins a tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= CHN_A;
    end else if (upd) begin
      ptr <= ~last;
    end else begin
      ptr <= ptr;
    end
  end

  // Grant: a lone requester always wins; a tie goes to the pointer.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!en) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end else if (req_a && req_b) begin
      gnt_a = (ptr == CHN_A);
      gnt_b = (ptr == CHN_B);
    end else begin
      gnt_a = req_a;
      gnt_b = req_b;
    end
  end

endmodule

// File: rtl/vend_sched.sv
// vend_sched -- two-channel coin vending scheduler.
//   clk, rst                         : clock, asynchronous active-high reset
//   coin_{a,b}_vld/_val/_rdy         : coin offer handshakes (val 1 or 2 units; 0/3 invalid)
//   restock_vld, restock_cnt         : add items to stock (saturating)
//   dispense_vld/_ack/_chn/_chg      : item hand-out, held until acknowledged
//   refund_vld/_chn/_val             : one-cycle refund of collected credit after timeout
//   bad_coin                         : one-cycle pulse after an invalid coin is taken
//   sold_out, stock, busy            : status
module vend_sched
  import vend_pkg::*;
#(
  parameter int PRICE   = PRICE_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int STOCK_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               coin_a_vld,
  input  logic [1:0]         coin_a_val,
  output logic               coin_a_rdy,
  input  logic               coin_b_vld,
  input  logic [1:0]         coin_b_val,
  output logic               coin_b_rdy,
  input  logic               restock_vld,
  input  logic [STOCK_W-1:0] restock_cnt,
  output logic               dispense_vld,
  input  logic               dispense_ack,
  output logic               dispense_chn,
  output logic [1:0]         dispense_chg,
  output logic               refund_vld,
  output logic               refund_chn,
  output logic [2:0]         refund_val,
  output logic               bad_coin,
  output logic               sold_out,
  output logic [STOCK_W-1:0] stock,
  output logic               busy
);

  localparam int              TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TLAST  = TW'(TIMEOUT - 1);
  localparam logic [3:0]      PRICE4 = 4'(PRICE);
  localparam logic [2:0]      PRICE3 = 3'(PRICE);

  state_t             state, state_nx;
  logic [2:0]         credit, credit_nx;
  logic               owner, owner_nx;
  logic [TW-1:0]      tcnt, tcnt_nx;
  logic [STOCK_W-1:0] stock_nx;
  logic               bad_nx;
  logic               dec, ptr_upd;
  logic               arb_en, gnt_a, gnt_b;
  logic               acc_a, acc_b, acc, acc_chn, acc_ok;
  logic [1:0]         acc_val;
  logic [3:0]         sum;
  logic [STOCK_W:0]   stock_sum;
  logic [STOCK_W-1:0] stock_sat;

  // New customers are only arbitrated while idle and something is left to sell.
  assign arb_en   = (state == ST_IDLE) && (stock != '0);
  assign sold_out = (stock == '0);
  assign busy     = (state != ST_IDLE);

  vend_rr_arb u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .req_a (coin_a_vld),
    .req_b (coin_b_vld),
    .upd   (ptr_upd),
    .last  (owner),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  // Ready: arbiter decides in IDLE, only the owner may pay in COLLECT.
  always_comb begin
    coin_a_rdy = 1'b0;
    coin_b_rdy = 1'b0;
    if (state == ST_IDLE) begin
      coin_a_rdy = gnt_a;
      coin_b_rdy = gnt_b;
    end else if (state == ST_COLLECT) begin
      coin_a_rdy = (owner == CHN_A);
      coin_b_rdy = (owner == CHN_B);
    end else begin
      coin_a_rdy = 1'b0;
      coin_b_rdy = 1'b0;
    end
  end

  // Accepted coin this cycle; credit is 0 in IDLE so one sum serves both states.
  always_comb begin
    acc_a   = coin_a_vld & coin_a_rdy;
    acc_b   = coin_b_vld & coin_b_rdy;
    acc     = acc_a | acc_b;
    acc_chn = acc_b ? CHN_B : CHN_A;
    acc_val = acc_b ? coin_b_val : coin_a_val;
    acc_ok  = coin_ok(acc_val);
    sum     = {1'b0, credit} + {1'b0, coin_units(acc_val)};
  end

  // Next-state logic; credit holds the full paid amount so change is credit - PRICE.
  always_comb begin
    state_nx  = state;
    credit_nx = credit;
    owner_nx  = owner;
    tcnt_nx   = tcnt;
    bad_nx    = acc & ~acc_ok;
    dec       = 1'b0;
    ptr_upd   = 1'b0;
    case (state)
      ST_IDLE: begin
        tcnt_nx = '0;
        if (acc && acc_ok) begin
          owner_nx  = acc_chn;
          credit_nx = sum[2:0];
          state_nx  = (sum >= PRICE4) ? ST_DISPENSE : ST_COLLECT;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (acc) begin
          tcnt_nx = '0;
          if (acc_ok) begin
            credit_nx = sum[2:0];
            state_nx  = (sum >= PRICE4) ? ST_DISPENSE : ST_COLLECT;
          end else begin
            credit_nx = credit;
          end
        end else if (tcnt == TLAST) begin
          tcnt_nx  = '0;
          state_nx = ST_REFUND;
        end else begin
          tcnt_nx = tcnt + TW'(1);
        end
      end
      ST_DISPENSE: begin
        if (dispense_ack) begin
          dec       = 1'b1;
          credit_nx = '0;
          ptr_upd   = 1'b1;
          state_nx  = ST_IDLE;
        end else begin
          state_nx = ST_DISPENSE;
        end
      end
      ST_REFUND: begin
        credit_nx = '0;
        ptr_upd   = 1'b1;
        state_nx  = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Stock: saturating restock first, then the sale is taken off the saturated value.
  always_comb begin
    stock_sum = {1'b0, stock} + (restock_vld ? {1'b0, restock_cnt} : {(STOCK_W+1){1'b0}});
    stock_sat = stock_sum[STOCK_W] ? {STOCK_W{1'b1}} : stock_sum[STOCK_W-1:0];
    if (dec && (stock_sat != '0)) begin
      stock_nx = stock_sat - STOCK_W'(1);
    end else begin
      stock_nx = stock_sat;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      credit   <= 3'd0;
      owner    <= CHN_A;
      tcnt     <= '0;
      stock    <= '0;
      bad_coin <= 1'b0;
    end else begin
      state    <= state_nx;
      credit   <= credit_nx;
      owner    <= owner_nx;
      tcnt     <= tcnt_nx;
      stock    <= stock_nx;
      bad_coin <= bad_nx;
    end
  end

  // Handshake outputs decoded from registered state; data is zero when not valid.
  always_comb begin
    dispense_vld = 1'b0;
    dispense_chn = 1'b0;
    dispense_chg = 2'd0;
    refund_vld   = 1'b0;
    refund_chn   = 1'b0;
    refund_val   = 3'd0;
    case (state)
      ST_DISPENSE: begin
        dispense_vld = 1'b1;
        dispense_chn = owner;
        dispense_chg = 2'(credit - PRICE3);
      end
      ST_REFUND: begin
        refund_vld = 1'b1;
        refund_chn = owner;
        refund_val = credit;
      end
      default: begin
        dispense_vld = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_vend_sched.sv
module tb_vend_sched;

  localparam int PRICE = 4, TIMEOUT = 16, STOCK_W = 8, SMAX = 255;
  localparam int K_DISP = 0, K_REF = 1, K_BAD = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               coin_a_vld, coin_b_vld, coin_a_rdy, coin_b_rdy;
  logic [1:0]         coin_a_val, coin_b_val;
  logic               restock_vld;
  logic [STOCK_W-1:0] restock_cnt;
  logic               dispense_vld, dispense_ack, dispense_chn;
  logic [1:0]         dispense_chg;
  logic               refund_vld, refund_chn;
  logic [2:0]         refund_val;
  logic               bad_coin, sold_out, busy;
  logic [STOCK_W-1:0] stock;

  vend_sched #(.PRICE(PRICE), .TIMEOUT(TIMEOUT), .STOCK_W(STOCK_W)) dut (
    .clk(clk), .rst(rst),
    .coin_a_vld(coin_a_vld), .coin_a_val(coin_a_val), .coin_a_rdy(coin_a_rdy),
    .coin_b_vld(coin_b_vld), .coin_b_val(coin_b_val), .coin_b_rdy(coin_b_rdy),
    .restock_vld(restock_vld), .restock_cnt(restock_cnt),
    .dispense_vld(dispense_vld), .dispense_ack(dispense_ack),
    .dispense_chn(dispense_chn), .dispense_chg(dispense_chg),
    .refund_vld(refund_vld), .refund_chn(refund_chn), .refund_val(refund_val),
    .bad_coin(bad_coin), .sold_out(sold_out), .stock(stock), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int chn; int val; } ev_t;
  ev_t        exp_q[$];
  int         n_chk = 0, n_pass = 0;
  int         m_stock = 0, m_ptr = 0;
  logic [1:0] cq[$];

  function automatic void check_eq(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endfunction

  function automatic int sat(input int v);
    return (v > SMAX) ? SMAX : v;
  endfunction

  function automatic void push(input int kind, input int chn, input int val);
    ev_t e;
    e.kind = kind; e.chn = chn; e.val = val;
    exp_q.push_back(e);
  endfunction

  task automatic pop_cmp(input int kind, input int chn, input int val, output ev_t e);
    check_eq("event_expected", int'(exp_q.size() > 0), 1);
    if (exp_q.size() == 0) begin
      e.kind = kind; e.chn = chn; e.val = val;
    end else begin
      e = exp_q.pop_front();
      check_eq("event_kind", kind, e.kind);
      if (kind == e.kind && kind != K_BAD) begin
        check_eq((kind == K_DISP) ? "dispense_chn" : "refund_chn", chn, e.chn);
        check_eq((kind == K_DISP) ? "dispense_chg" : "refund_val", val, e.val);
      end
    end
  endtask

  // Monitor: pops the expected event whenever the DUT presents one.
  initial begin : monitor
    ev_t e, cur;
    bit  in_disp, prev_ref;
    in_disp = 1'b0; prev_ref = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_disp = 1'b0; prev_ref = 1'b0;
      end else begin
        if (bad_coin) pop_cmp(K_BAD, 0, 0, e);
        if (refund_vld) begin
          check_eq("refund_single_cycle", int'(prev_ref), 0);
          pop_cmp(K_REF, int'(refund_chn), int'(refund_val), e);
        end
        prev_ref = refund_vld;
        if (dispense_vld) begin
          if (!in_disp) begin
            pop_cmp(K_DISP, int'(dispense_chn), int'(dispense_chg), cur);
            in_disp = 1'b1;
          end else begin
            check_eq("dispense_chn_hold", int'(dispense_chn), cur.chn);
            check_eq("dispense_chg_hold", int'(dispense_chg), cur.val);
          end
        end else begin
          in_disp = 1'b0;
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check_eq("rst_dispense_vld", int'(dispense_vld), 0);
    check_eq("rst_dispense_chg", int'(dispense_chg), 0);
    check_eq("rst_refund_vld", int'(refund_vld), 0);
    check_eq("rst_refund_val", int'(refund_val), 0);
    check_eq("rst_bad_coin", int'(bad_coin), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_stock", int'(stock), 0);
    check_eq("rst_sold_out", int'(sold_out), 1);
  endtask

  task automatic apply_reset();
    coin_a_vld = 0; coin_b_vld = 0; coin_a_val = 0; coin_b_val = 0;
    restock_vld = 0; restock_cnt = 0; dispense_ack = 0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    m_stock = 0; m_ptr = 0;
    exp_q.delete();
  endtask

  task automatic do_restock(input int cnt);
    @(posedge clk); #1;
    restock_vld = 1'b1; restock_cnt = STOCK_W'(cnt);
    @(posedge clk); #1;
    restock_vld = 1'b0;
    m_stock = sat(m_stock + cnt);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_reached", int'(busy || exp_q.size() != 0), 0);
    check_eq("stock", int'(stock), m_stock);
    check_eq("sold_out", int'(sold_out), int'(m_stock == 0));
  endtask

  task automatic offer(input int chn, input logic [1:0] val, input bit both, output bit ok);
    @(posedge clk); #1;
    if (chn == 0 || both) begin coin_a_vld = 1'b1; coin_a_val = val; end
    if (chn == 1 || both) begin coin_b_vld = 1'b1; coin_b_val = val; end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (both && i == 0) begin
        check_eq("grant_a", int'(coin_a_rdy), int'(chn == 0));
        check_eq("grant_b", int'(coin_b_rdy), int'(chn == 1));
      end
      ok = (chn == 0) ? coin_a_rdy : coin_b_rdy;
      @(posedge clk);
    end
    #1;
    coin_a_vld = 1'b0; coin_b_vld = 1'b0;
    check_eq("coin_rdy_seen", int'(ok), 1);
  endtask

  // One customer session paying the coins in cq; the model is plain arithmetic on units.
  task automatic session(input int chn, input bit contend, input int ack_restock, input bit do_ack);
    int  credit, u;
    bit  owned, done, ok;
    credit = 0; owned = 0; done = 0;
    for (int k = 0; k < cq.size() && !done; k++) begin
      if (k > 0) repeat ($urandom_range(0, 3)) @(posedge clk);
      offer(chn, cq[k], contend && (k == 0), ok);
      if (!ok) break;
      u = (cq[k] == 2'd1) ? 1 : (cq[k] == 2'd2) ? 2 : 0;
      if (u == 0) begin
        push(K_BAD, 0, 0);
      end else begin
        owned = 1; credit += u;
        if (credit >= PRICE) begin
          push(K_DISP, chn, credit - PRICE);
          done = 1;
        end
      end
    end
    if (done) begin
      if (do_ack) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        dispense_ack = 1'b1;
        if (ack_restock > 0) begin restock_vld = 1'b1; restock_cnt = STOCK_W'(ack_restock); end
        @(posedge clk); #1;
        dispense_ack = 1'b0; restock_vld = 1'b0;
        m_stock = sat(m_stock + ack_restock) - 1;
        m_ptr = 1 - chn;
      end
    end else if (owned) begin
      push(K_REF, chn, credit);
      m_ptr = 1 - chn;
    end
    if (do_ack) wait_idle();
  endtask

  task automatic soldout_probe();
    @(posedge clk); #1;
    coin_a_vld = 1'b1; coin_a_val = 2'd1; coin_b_vld = 1'b1; coin_b_val = 2'd2;
    repeat (3) begin
      @(negedge clk);
      check_eq("soldout_rdy_a", int'(coin_a_rdy), 0);
      check_eq("soldout_rdy_b", int'(coin_b_rdy), 0);
    end
    @(posedge clk); #1;
    coin_a_vld = 1'b0; coin_b_vld = 1'b0;
    check_eq("soldout_busy", int'(busy), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int r, len, chn;
    bit contend;
    apply_reset();

    // Basic sale on A, then B with 2+2, then A with change.
    do_restock(5);
    cq = '{2'd1, 2'd1, 2'd1, 2'd1}; session(0, 0, 0, 1);
    cq = '{2'd2, 2'd2};             session(1, 0, 0, 1);
    cq = '{2'd1, 2'd1, 2'd1, 2'd2}; session(0, 0, 0, 1);
    do_restock(20);

    // Contention: make the pointer favour A, then two contests.
    cq = '{2'd2, 2'd2};             session(1, 0, 0, 1);
    cq = '{2'd1, 2'd2, 2'd1};       session(m_ptr, 1, 0, 1);
    cq = '{2'd2, 2'd2};             session(m_ptr, 1, 0, 1);

    // Timeout refund and invalid coins.
    cq = '{2'd1};                   session(0, 0, 0, 1);
    cq = '{2'd1, 2'd3, 2'd1, 2'd1, 2'd1}; session(0, 0, 0, 1);
    cq = '{2'd0};                   session(1, 0, 0, 1);

    // Randomized sessions.
    for (int s = 0; s < 40; s++) begin
      if (m_stock == 0) begin
        soldout_probe();
        do_restock($urandom_range(1, 4));
      end else if ($urandom_range(0, 5) == 0) begin
        do_restock($urandom_range(0, 3));
      end
      cq.delete();
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        r = $urandom_range(0, 19);
        cq.push_back((r < 8) ? 2'd1 : (r < 16) ? 2'd2 : (r < 18) ? 2'd0 : 2'd3);
      end
      contend = ($urandom_range(0, 2) == 0);
      if (contend) cq[0] = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd2;
      chn = contend ? m_ptr : $urandom_range(0, 1);
      session(chn, contend, ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0, 1);
    end

    // Saturation, and a sale acknowledged together with a saturating restock.
    do_restock(250); do_restock(250);
    wait_idle();
    cq = '{2'd2, 2'd2};             session(1, 0, 10, 1);

    // Last item sold, then restock in the ack cycle.
    apply_reset();
    do_restock(1);
    cq = '{2'd2, 2'd2};             session(0, 0, 0, 1);
    soldout_probe();
    do_restock(1);
    cq = '{2'd1, 2'd1, 2'd2};       session(0, 0, 3, 1);

    // Reset while dispensing drops the transaction.
    do_restock(2);
    cq = '{2'd2, 2'd2};             session(0, 0, 0, 0);
    @(negedge clk);
    check_eq("dispense_before_rst", int'(dispense_vld), 1);
    @(negedge clk);
    check_eq("queue_before_rst", exp_q.size(), 0);
    #1;
    apply_reset();
    cq = '{2'd1, 2'd1, 2'd2};
    do_restock(1);
    session(1, 0, 0, 1);

    repeat (3) @(negedge clk);
    check_eq("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
